uart_apb_regs: RTL and testbench

UART_APB_REGS -- requirements
Module: uart_apb_regs

---
 rtl/uart_apb_regs.sv | 127 ++++++++++++
 tb/tb_uart_apb_regs.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_regs.sv
// APB register front-end for the UART core: baud divider, TX byte strobe with a 2-deep
// in-flight count, RX FIFO pop, sticky status and interrupt.
module uart_apb_regs #(
  parameter logic [9:0] RESET_DIV_INT  = 10'd27,
  parameter logic [3:0] RESET_DIV_FRAC = 4'd2
) (
  input  logic        clk,
  input  logic        rst_n_sync,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [4:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [9:0]  div_int,
  output logic [3:0]  div_frac,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_done,
  input  logic [7:0]  rx_byte,
  input  logic        rx_irq,
  output logic        rxfifo_ren_ext,
  output logic        irq
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_DIV    = 3'd2;
  localparam logic [2:0] A_IE     = 3'd3;
  localparam logic [2:0] A_ISR    = 3'd4;

  logic [1:0] tx_cnt;
  logic       tx_ovf;
  logic       rx_unf;
  logic       tx_pend;
  logic       tx_done_q;
  logic [1:0] ie;

  logic [2:0] reg_idx;
  logic       access;
  logic       wr;
  logic       rd;
  logic       bad_addr;
  logic       tx_busy;
  logic       tx_rise;
  logic       tx_issue;
  logic       tx_ovf_set;
  logic       rx_pop;
  logic       rx_unf_set;
  logic       div_err;
  logic       div_wr;
  logic       sts_wr;
  logic       isr_wr;
  logic       unused_bits;

  assign reg_idx    = paddr[4:2];
  assign access     = psel & penable;
  assign wr         = access & pwrite;
  assign rd         = access & ~pwrite;
  assign bad_addr   = (reg_idx > A_ISR);
  assign tx_busy    = (tx_cnt != 2'd0);
  assign tx_rise    = tx_done & ~tx_done_q;
  assign tx_issue   = wr & (reg_idx == A_DATA) & (tx_cnt != 2'd2);
  assign tx_ovf_set = wr & (reg_idx == A_DATA) & (tx_cnt == 2'd2);
  // A DATA read landing in the pop cycle would see the old head; never pop twice in a row.
  assign rx_pop     = rd & (reg_idx == A_DATA) & rx_irq & ~rxfifo_ren_ext;
  assign rx_unf_set = rd & (reg_idx == A_DATA) & ~rx_irq;
  assign div_err    = wr & (reg_idx == A_DIV) & tx_busy;
  assign div_wr     = wr & (reg_idx == A_DIV) & ~tx_busy;
  assign sts_wr     = wr & (reg_idx == A_STATUS);
  assign isr_wr     = wr & (reg_idx == A_ISR);

  assign pready      = 1'b1;
  assign pslverr     = access & (bad_addr | tx_ovf_set | rx_unf_set | div_err);
  assign unused_bits = ^{pwdata[31:14], paddr[1:0]};

  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (reg_idx)
        A_DATA:   if (rx_irq) prdata = {24'h0, rx_byte};
        A_STATUS: prdata = {26'h0, tx_cnt, rx_unf, tx_ovf, tx_busy, rx_irq};
        A_DIV:    prdata = {18'h0, div_int, div_frac};
        A_IE:     prdata = {30'h0, ie};
        A_ISR:    prdata = {30'h0, tx_pend, rx_irq};
        default:  prdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      tx_cnt         <= 2'd0;
      tx_ovf         <= 1'b0;
      rx_unf         <= 1'b0;
      tx_pend        <= 1'b0;
      tx_done_q      <= 1'b0;
      ie             <= 2'b00;
      div_int        <= RESET_DIV_INT;
      div_frac       <= RESET_DIV_FRAC;
      tx_byte        <= 8'h00;
      tx_valid       <= 1'b0;
      rxfifo_ren_ext <= 1'b0;
      irq            <= 1'b0;
    end else begin
      tx_done_q      <= tx_done;
      tx_valid       <= tx_issue;
      rxfifo_ren_ext <= rx_pop;
      if (tx_issue) tx_byte <= pwdata[7:0];
      // Issue and completion in the same cycle cancel out.
      if (tx_issue && !tx_rise) tx_cnt <= tx_cnt + 2'd1;
      else if (tx_rise && !tx_issue && tx_busy) tx_cnt <= tx_cnt - 2'd1;
      tx_ovf  <= tx_ovf_set | (tx_ovf & ~(sts_wr & pwdata[2]));
      rx_unf  <= rx_unf_set | (rx_unf & ~(sts_wr & pwdata[3]));
      tx_pend <= tx_rise | (tx_pend & ~(isr_wr & pwdata[1]));
      if (div_wr) begin
        div_int  <= (pwdata[13:4] == 10'd0) ? 10'd1 : pwdata[13:4];
        div_frac <= pwdata[3:0];
      end
      if (wr && reg_idx == A_IE) ie <= pwdata[1:0];
      irq <= (ie[0] & rx_irq) | (ie[1] & tx_pend);
    end
  end

endmodule

// File: tb/tb_uart_apb_regs.sv
// Bench for uart_apb_regs: directed vector table, hand-written corner sequences, and
// randomized accesses checked against a register-level reference model.
module tb_uart_apb_regs;

  logic        clk;
  logic        rst_n_sync;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [9:0]  div_int;
  logic [3:0]  div_frac;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_done;
  logic [7:0]  rx_byte;
  logic        rx_irq;
  logic        rxfifo_ren_ext;
  logic        irq;

  uart_apb_regs dut (
    .clk(clk), .rst_n_sync(rst_n_sync),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .div_int(div_int), .div_frac(div_frac),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_done(tx_done),
    .rx_byte(rx_byte), .rx_irq(rx_irq), .rxfifo_ren_ext(rxfifo_ren_ext), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One APB transfer; returns at completion edge + 1ns so strobes are visible.
  task automatic apb(input bit wr, input logic [4:0] a, input logic [31:0] d, input bit raise_done,
                     output logic [31:0] rd, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    if (raise_done) tx_done = 1'b1;
    #1;
    rd  = prdata;
    err = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; tx_done = 1'b0;
  endtask

  task automatic pulse_done(input int len);
    @(negedge clk);
    tx_done = 1'b1;
    repeat (len) @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_sync = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; tx_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n_sync = 1'b1;
  endtask

  // Reference model: registers as plain variables, updated by the rules of the register map.
  int         m_cnt;
  bit         m_ovf, m_unf, m_pend;
  logic [1:0] m_ie;
  logic [9:0] m_di;
  logic [3:0] m_df;
  logic [7:0] m_txb;

  task automatic model_reset();
    m_cnt = 0; m_ovf = 0; m_unf = 0; m_pend = 0; m_ie = 2'b00;
    m_di = 10'd27; m_df = 4'd2; m_txb = 8'h00;
  endtask

  task automatic model_done();
    if (m_cnt > 0) m_cnt = m_cnt - 1;
    m_pend = 1;
  endtask

  task automatic model_access(input bit wr, input logic [4:0] a, input logic [31:0] d,
                              input bit rxi, input logic [7:0] rxb,
                              output logic [31:0] erd, output logic eerr,
                              output bit etxv, output bit epop);
    int reg_no;
    reg_no = int'(a) / 4;
    erd = 0; eerr = 0; etxv = 0; epop = 0;
    case (reg_no)
      0: if (wr) begin
           if (m_cnt < 2) begin m_cnt = m_cnt + 1; m_txb = d[7:0]; etxv = 1; end
           else begin m_ovf = 1; eerr = 1; end
         end else begin
           if (rxi) begin erd = 32'(rxb); epop = 1; end
           else begin m_unf = 1; eerr = 1; end
         end
      1: if (wr) begin
           if (d[2]) m_ovf = 0;
           if (d[3]) m_unf = 0;
         end else
           erd = 32'(rxi) + 2 * 32'(m_cnt != 0) + 4 * 32'(m_ovf) + 8 * 32'(m_unf) + 16 * 32'(m_cnt);
      2: if (wr) begin
           if (m_cnt != 0) eerr = 1;
           else begin
             m_di = (d[13:4] == 0) ? 10'd1 : d[13:4];
             m_df = d[3:0];
           end
         end else erd = 16 * 32'(m_di) + 32'(m_df);
      3: if (wr) m_ie = d[1:0]; else erd = 32'(m_ie);
      4: if (wr) begin
           if (d[1]) m_pend = 0;
         end else erd = 2 * 32'(m_pend) + 32'(rxi);
      default: eerr = 1;
    endcase
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  a;
    logic [31:0] d;
    bit          rxi;
    logic [7:0]  rxb;
    logic [31:0] erd;
    bit          eerr;
    bit          estb;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] rd, erd;
  logic        err, eerr;
  bit          etxv, epop, rw;
  logic [4:0]  ra;
  logic [31:0] rdat;
  int          pick;

  initial begin
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    tx_done = 0; rx_byte = 0; rx_irq = 0; rst_n_sync = 0;

    // Reset values, observed while reset is held.
    #12;
    chk("reset div_int", div_int, 10'd27);
    chk("reset div_frac", div_frac, 4'd2);
    chk("reset tx_byte", tx_byte, 8'h00);
    chk("reset tx_valid", tx_valid, 1'b0);
    chk("reset rxfifo_ren_ext", rxfifo_ren_ext, 1'b0);
    chk("reset irq", irq, 1'b0);
    chk("pready", pready, 1'b1);
    do_reset();

    //           wr addr    data  rxi rxb    exp_rd  err stb
    vt.push_back('{0, 5'h04, 32'h0,  0, 8'h00, 32'h00,  0, 0});
    vt.push_back('{0, 5'h08, 32'h0,  0, 8'h00, 32'h1B2, 0, 0});
    vt.push_back('{1, 5'h00, 32'hA5, 0, 8'h00, 32'h00,  0, 1});
    vt.push_back('{0, 5'h04, 32'h0,  0, 8'h00, 32'h12,  0, 0});
    vt.push_back('{1, 5'h00, 32'h11, 0, 8'h00, 32'h00,  0, 1});
    vt.push_back('{1, 5'h00, 32'h22, 0, 8'h00, 32'h00,  1, 0});
    vt.push_back('{0, 5'h04, 32'h0,  0, 8'h00, 32'h26,  0, 0});
    vt.push_back('{1, 5'h04, 32'h4,  0, 8'h00, 32'h00,  0, 0});
    vt.push_back('{0, 5'h04, 32'h0,  0, 8'h00, 32'h22,  0, 0});
    vt.push_back('{1, 5'h08, 32'h0,  0, 8'h00, 32'h00,  1, 0});
    vt.push_back('{0, 5'h08, 32'h0,  0, 8'h00, 32'h1B2, 0, 0});
    vt.push_back('{0, 5'h00, 32'h0,  1, 8'h3C, 32'h3C,  0, 1});
    vt.push_back('{0, 5'h00, 32'h0,  0, 8'h3C, 32'h00,  1, 0});
    vt.push_back('{0, 5'h04, 32'h0,  0, 8'h00, 32'h2A,  0, 0});
    vt.push_back('{1, 5'h04, 32'hC,  0, 8'h00, 32'h00,  0, 0});
    vt.push_back('{0, 5'h04, 32'h0,  1, 8'h00, 32'h23,  0, 0});
    vt.push_back('{0, 5'h14, 32'h0,  0, 8'h00, 32'h00,  1, 0});
    vt.push_back('{1, 5'h1C, 32'h5,  0, 8'h00, 32'h00,  1, 0});
    vt.push_back('{1, 5'h0C, 32'h3,  0, 8'h00, 32'h00,  0, 0});
    vt.push_back('{0, 5'h0C, 32'h0,  0, 8'h00, 32'h03,  0, 0});
    vt.push_back('{0, 5'h10, 32'h0,  1, 8'h00, 32'h01,  0, 0});
    vt.push_back('{0, 5'h05, 32'h0,  0, 8'h00, 32'h22,  0, 0});

    foreach (vt[i]) begin
      rx_irq  = vt[i].rxi;
      rx_byte = vt[i].rxb;
      apb(vt[i].wr, vt[i].a, vt[i].d, 1'b0, rd, err);
      if (!vt[i].wr) chk($sformatf("vec%0d prdata", i), rd, vt[i].erd);
      chk($sformatf("vec%0d pslverr", i), err, vt[i].eerr);
      if (vt[i].wr) begin
        chk($sformatf("vec%0d tx_valid", i), tx_valid, vt[i].estb);
        if (vt[i].estb) chk($sformatf("vec%0d tx_byte", i), tx_byte, vt[i].d[7:0]);
      end else
        chk($sformatf("vec%0d rxfifo_ren_ext", i), rxfifo_ren_ext, vt[i].estb);
      @(posedge clk); #1;
      chk($sformatf("vec%0d strobes drop", i), {tx_valid, rxfifo_ren_ext}, 2'b00);
    end

    // TX completion, simultaneous issue/completion, tx-done interrupt and W1C.
    do_reset();
    rx_irq = 0;
    apb(1, 5'h0C, 32'h2, 0, rd, err);
    apb(1, 5'h00, 32'h55, 0, rd, err);
    apb(1, 5'h00, 32'h66, 1, rd, err);
    chk("simul issue tx_valid", tx_valid, 1'b1);
    apb(0, 5'h04, 32'h0, 0, rd, err);
    chk("simul issue STATUS", rd, 32'h12);
    apb(1, 5'h10, 32'h2, 0, rd, err);
    @(posedge clk); #1;
    chk("ISR clear irq", irq, 1'b0);
    pulse_done(3);
    apb(0, 5'h04, 32'h0, 0, rd, err);
    chk("done STATUS", rd, 32'h00);
    apb(0, 5'h10, 32'h0, 0, rd, err);
    chk("done ISR", rd, 32'h02);
    chk("done irq", irq, 1'b1);
    apb(1, 5'h10, 32'h2, 1, rd, err);
    apb(0, 5'h10, 32'h0, 0, rd, err);
    chk("ISR set wins", rd, 32'h02);
    apb(1, 5'h10, 32'h2, 0, rd, err);
    @(posedge clk); #1;
    chk("ISR W1C irq", irq, 1'b0);

    // Divider writes: idle, zero, and while busy.
    apb(1, 5'h08, 32'h1B2, 0, rd, err);
    chk("div idle err", err, 1'b0);
    chk("div idle int", div_int, 10'd27);
    chk("div idle frac", div_frac, 4'd2);
    apb(1, 5'h08, 32'h000, 0, rd, err);
    chk("div zero int", div_int, 10'd1);
    chk("div zero frac", div_frac, 4'd0);
    apb(1, 5'h00, 32'h77, 0, rd, err);
    apb(1, 5'h08, 32'h1B2, 0, rd, err);
    chk("div busy err", err, 1'b1);
    chk("div busy int", div_int, 10'd1);
    chk("div busy frac", div_frac, 4'd0);

    // Asynchronous reset with strobe pending, tx_cnt=2, IE=3.
    rx_irq = 1;
    apb(1, 5'h0C, 32'h3, 0, rd, err);
    apb(1, 5'h00, 32'h88, 0, rd, err);
    chk("pre-reset tx_valid", tx_valid, 1'b1);
    chk("pre-reset irq", irq, 1'b1);
    #2;
    rst_n_sync = 0;
    #1;
    chk("async rst tx_valid", tx_valid, 1'b0);
    chk("async rst irq", irq, 1'b0);
    chk("async rst tx_byte", tx_byte, 8'h00);
    chk("async rst div_int", div_int, 10'd27);
    chk("async rst div_frac", div_frac, 4'd2);
    chk("async rst ren", rxfifo_ren_ext, 1'b0);
    @(negedge clk);
    rst_n_sync = 1;
    apb(0, 5'h0C, 32'h0, 0, rd, err);
    chk("post-reset IE", rd, 32'h0);
    apb(0, 5'h04, 32'h0, 0, rd, err);
    chk("post-reset STATUS", rd, 32'h1);

    // Randomized accesses against the model.
    do_reset();
    model_reset();
    for (int i = 0; i < 300; i++) begin
      rx_irq  = 1'($urandom_range(0, 1));
      rx_byte = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        pulse_done($urandom_range(1, 3));
        model_done();
      end
      rw   = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 6);
      ra   = (pick < 5) ? 5'(pick * 4) : 5'($urandom_range(0, 31));
      rdat = $urandom;
      if ($urandom_range(0, 3) == 0) rdat[13:4] = 10'd0;
      model_access(rw, ra, rdat, rx_irq, rx_byte, erd, eerr, etxv, epop);
      apb(rw, ra, rdat, 0, rd, err);
      if (!rw) chk($sformatf("rnd%0d prdata", i), rd, erd);
      chk($sformatf("rnd%0d pslverr", i), err, eerr);
      chk($sformatf("rnd%0d tx_valid", i), tx_valid, etxv);
      chk($sformatf("rnd%0d ren", i), rxfifo_ren_ext, epop);
      chk($sformatf("rnd%0d tx_byte", i), tx_byte, m_txb);
      chk($sformatf("rnd%0d div", i), {div_int, div_frac}, {m_di, m_df});
      @(posedge clk); #1;
      chk($sformatf("rnd%0d irq", i), irq, (m_ie[0] & rx_irq) | (m_ie[1] & m_pend));
      chk($sformatf("rnd%0d strobes drop", i), {tx_valid, rxfifo_ren_ext}, 2'b00);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
